// File: rtl/reorder_buffer_nw.sv
// Parametrised superscalar reorder buffer: DW-wide dispatch, CW completion
// ports, RW-wide in-order retire, with backpressure and exception flush.
module reorder_buffer_nw #(
  parameter int PC_SIZE        = 32,
  parameter int WORD_SIZE      = 32,
  parameter int NUM_P_REGS     = 64,
  parameter int ROB_SIZE       = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int COMPLETE_WIDTH = 3,
  parameter int RETIRE_WIDTH   = 2,
  localparam int PW = $clog2(NUM_P_REGS),
  localparam int IW = $clog2(ROB_SIZE),
  localparam int DW = DISPATCH_WIDTH,
  localparam int CW = COMPLETE_WIDTH,
  localparam int RW = RETIRE_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [DW-1:0]           dispatch_valid_i,
  output logic                    dispatch_ready_o,
  input  logic [DW*PW-1:0]        dispatch_dest_i,
  input  logic [DW*PW-1:0]        dispatch_old_dest_i,
  input  logic [DW-1:0]           dispatch_regwrite_i,
  input  logic [DW*PC_SIZE-1:0]   dispatch_pc_i,
  output logic [DW*IW-1:0]        dispatch_index_o,
  input  logic [CW-1:0]           complete_valid_i,
  input  logic [CW*IW-1:0]        complete_index_i,
  input  logic [CW*WORD_SIZE-1:0] complete_val_i,
  input  logic [CW-1:0]           complete_exc_i,
  output logic [RW-1:0]           retire_valid_o,
  output logic [RW-1:0]           retire_regwrite_o,
  output logic [RW*PW-1:0]        retire_dest_o,
  output logic [RW*PW-1:0]        retire_old_dest_o,
  output logic [RW*WORD_SIZE-1:0] retire_val_o,
  output logic                    flush_o,
  output logic [PC_SIZE-1:0]      flush_pc_o,
  output logic [IW:0]             count_o,
  output logic                    empty_o
);

  localparam int CNTW = IW + 1;

  logic [ROB_SIZE-1:0]  busy_q;
  logic [ROB_SIZE-1:0]  done_q;
  logic [ROB_SIZE-1:0]  exc_q;
  logic [ROB_SIZE-1:0]  rw_q;
  logic [PW-1:0]        dest_q [ROB_SIZE];
  logic [PW-1:0]        old_q  [ROB_SIZE];
  logic [PC_SIZE-1:0]   pc_q   [ROB_SIZE];
  logic [WORD_SIZE-1:0] val_q  [ROB_SIZE];

  logic [IW-1:0]   head_q;
  logic [IW-1:0]   tail_q;
  logic [CNTW-1:0] count_q;

  logic [IW-1:0]   ridx [RW];
  logic [IW-1:0]   didx [DW];
  logic            chain;
  logic [CNTW-1:0] ret_cnt;
  logic [CNTW-1:0] disp_cnt;
  logic [CNTW-1:0] free_cnt;
  logic            flush;
  logic            ready;

  // Head exception and backpressure decision.
  always_comb begin
    flush    = busy_q[head_q] & done_q[head_q] & exc_q[head_q];
    free_cnt = CNTW'(ROB_SIZE) - count_q;
    ready    = !flush && (free_cnt >= CNTW'(DW));
  end

  // Dispatch slot indices and accepted lane count.
  always_comb begin
    disp_cnt         = '0;
    dispatch_index_o = '0;
    for (int k = 0; k < DW; k++) begin
      didx[k] = tail_q + IW'(k);
      dispatch_index_o[k*IW +: IW] = didx[k];
      if (ready && dispatch_valid_i[k])
        disp_cnt = disp_cnt + CNTW'(1);
    end
  end

  // In-order retire window: a lane retires only if all older lanes do.
  always_comb begin
    chain             = 1'b1;
    ret_cnt           = '0;
    retire_valid_o    = '0;
    retire_regwrite_o = '0;
    retire_dest_o     = '0;
    retire_old_dest_o = '0;
    retire_val_o      = '0;
    for (int j = 0; j < RW; j++) begin
      ridx[j] = head_q + IW'(j);
      chain = chain & busy_q[ridx[j]] & done_q[ridx[j]]
            & ~exc_q[ridx[j]];
      retire_valid_o[j]    = chain;
      retire_regwrite_o[j] = rw_q[ridx[j]];
      retire_dest_o[j*PW +: PW]     = dest_q[ridx[j]];
      retire_old_dest_o[j*PW +: PW] = old_q[ridx[j]];
      retire_val_o[j*WORD_SIZE +: WORD_SIZE] = val_q[ridx[j]];
      if (chain)
        ret_cnt = ret_cnt + CNTW'(1);
    end
  end

  // Status outputs.
  always_comb begin
    dispatch_ready_o = ready;
    flush_o          = flush;
    flush_pc_o       = flush ? pc_q[head_q] : '0;
    count_o          = count_q;
    empty_o          = (count_q == '0);
  end

  // Entry state, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= '0;
      done_q  <= '0;
      exc_q   <= '0;
      rw_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < ROB_SIZE; e++) begin
        dest_q[e] <= '0;
        old_q[e]  <= '0;
        pc_q[e]   <= '0;
        val_q[e]  <= '0;
      end
    end else if (flush) begin
      busy_q  <= '0;
      done_q  <= '0;
      exc_q   <= '0;
      tail_q  <= head_q;
      count_q <= '0;
    end else begin
      for (int j = 0; j < RW; j++)
        if (retire_valid_o[j])
          busy_q[ridx[j]] <= 1'b0;
      if (ready) begin
        for (int k = 0; k < DW; k++) begin
          if (dispatch_valid_i[k]) begin
            busy_q[didx[k]] <= 1'b1;
            done_q[didx[k]] <= 1'b0;
            exc_q[didx[k]]  <= 1'b0;
            rw_q[didx[k]]   <= dispatch_regwrite_i[k];
            dest_q[didx[k]] <= dispatch_dest_i[k*PW +: PW];
            old_q[didx[k]]  <= dispatch_old_dest_i[k*PW +: PW];
            pc_q[didx[k]]   <= dispatch_pc_i[k*PC_SIZE +: PC_SIZE];
          end
        end
      end
      for (int c = 0; c < CW; c++) begin
        if (complete_valid_i[c] &&
            busy_q[complete_index_i[c*IW +: IW]]) begin
          done_q[complete_index_i[c*IW +: IW]] <= 1'b1;
          exc_q[complete_index_i[c*IW +: IW]]  <= complete_exc_i[c];
          val_q[complete_index_i[c*IW +: IW]]  <=
            complete_val_i[c*WORD_SIZE +: WORD_SIZE];
        end
      end
      head_q  <= head_q + ret_cnt[IW-1:0];
      tail_q  <= tail_q + disp_cnt[IW-1:0];
      count_q <= count_q + disp_cnt - ret_cnt;
    end
  end

endmodule

// File: tb/tb_reorder_buffer_nw.sv
// Bench for reorder_buffer_nw: step table with per-cycle expectations
// and an in-order scoreboard of retiring instructions.
module tb_reorder_buffer_nw;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  dispatch_valid_i;
  logic        dispatch_ready_o;
  logic [11:0] dispatch_dest_i;
  logic [11:0] dispatch_old_dest_i;
  logic [1:0]  dispatch_regwrite_i;
  logic [63:0] dispatch_pc_i;
  logic [7:0]  dispatch_index_o;
  logic [2:0]  complete_valid_i;
  logic [11:0] complete_index_i;
  logic [95:0] complete_val_i;
  logic [2:0]  complete_exc_i;
  logic [1:0]  retire_valid_o;
  logic [1:0]  retire_regwrite_o;
  logic [11:0] retire_dest_o;
  logic [11:0] retire_old_dest_o;
  logic [63:0] retire_val_o;
  logic        flush_o;
  logic [31:0] flush_pc_o;
  logic [4:0]  count_o;
  logic        empty_o;

  reorder_buffer_nw dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .dispatch_valid_i    (dispatch_valid_i),
    .dispatch_ready_o    (dispatch_ready_o),
    .dispatch_dest_i     (dispatch_dest_i),
    .dispatch_old_dest_i (dispatch_old_dest_i),
    .dispatch_regwrite_i (dispatch_regwrite_i),
    .dispatch_pc_i       (dispatch_pc_i),
    .dispatch_index_o    (dispatch_index_o),
    .complete_valid_i    (complete_valid_i),
    .complete_index_i    (complete_index_i),
    .complete_val_i      (complete_val_i),
    .complete_exc_i      (complete_exc_i),
    .retire_valid_o      (retire_valid_o),
    .retire_regwrite_o   (retire_regwrite_o),
    .retire_dest_o       (retire_dest_o),
    .retire_old_dest_o   (retire_old_dest_o),
    .retire_val_o        (retire_val_o),
    .flush_o             (flush_o),
    .flush_pc_o          (flush_pc_o),
    .count_o             (count_o),
    .empty_o             (empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]  dv;
    logic [2:0]  cv;
    logic [11:0] ci;
    logic [2:0]  cx;
    logic [2:0]  cbad;
    logic [4:0]  cnt;
    logic        rdy;
    logic [1:0]  rv;
    logic        fl;
  } vec_t;

  typedef struct {
    logic [5:0]  d;
    logic [5:0]  o;
    logic        rw;
    logic [31:0] v;
  } exp_t;

  vec_t        tbl[$];
  exp_t        q[$];
  logic [31:0] mval [16];
  logic [31:0] mpc  [16];
  logic [3:0]  mtail;
  logic [3:0]  mhead;
  int          seq;
  int          prev_cnt;
  logic [1:0]  prev_rv;
  logic        prev_fl;
  int          nvec;
  int          nmis;

  function automatic vec_t mk(
    input logic [1:0] dv, input logic [2:0] cv,
    input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
    input logic [2:0] cx, input logic [2:0] cbad,
    input logic [4:0] cnt, input logic rdy,
    input logic [1:0] rv, input logic fl);
    vec_t v;
    v.dv = dv; v.cv = cv; v.ci = {c2, c1, c0};
    v.cx = cx; v.cbad = cbad; v.cnt = cnt;
    v.rdy = rdy; v.rv = rv; v.fl = fl;
    return v;
  endfunction

  function automatic int pop2(input logic [1:0] x);
    return int'(x[0]) + int'(x[1]);
  endfunction

  function automatic logic [31:0] pc_of(input int s);
    return 32'(s * 4);
  endfunction

  function automatic logic [31:0] val_of(input int s);
    return 32'(s * 2 + 5);
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic run(input vec_t v);
    bit         acc;
    int         s;
    logic [3:0] idx;
    logic [3:0] ci;
    exp_t       e;
    dispatch_valid_i = v.dv;
    for (int k = 0; k < 2; k++) begin
      s = seq + k;
      dispatch_dest_i[k*6 +: 6]     = 6'((s + 33) % 64);
      dispatch_old_dest_i[k*6 +: 6] = 6'(s % 32);
      dispatch_regwrite_i[k]        = (s % 3) != 0;
      dispatch_pc_i[k*32 +: 32]     = pc_of(s);
    end
    chk("disp_idx0", 32'(dispatch_index_o[3:0]), 32'(mtail));
    chk("disp_idx1", 32'(dispatch_index_o[7:4]), 32'(4'(mtail + 4'd1)));
    acc = (v.dv != 2'b00) && (16 - prev_cnt >= 2) && !prev_fl;
    if (acc) begin
      for (int k = 0; k < 2; k++) begin
        if (v.dv[k]) begin
          s = seq + k;
          idx = mtail + 4'(k);
          mval[idx] = val_of(s);
          mpc[idx]  = pc_of(s);
          e.d = 6'((s + 33) % 64);
          e.o = 6'(s % 32);
          e.rw = (s % 3) != 0;
          e.v = val_of(s);
          q.push_back(e);
        end
      end
      seq   = seq + pop2(v.dv);
      mtail = mtail + 4'(pop2(v.dv));
    end
    complete_valid_i = v.cv;
    complete_exc_i   = v.cx;
    for (int c = 0; c < 3; c++) begin
      ci = v.ci[c*4 +: 4];
      complete_index_i[c*4 +: 4] = ci;
      complete_val_i[c*32 +: 32] = v.cbad[c] ? 32'hdead_beef : mval[ci];
    end
    @(posedge clk_i);
    #1;
    mhead = mhead + 4'(pop2(prev_rv));
    if (prev_fl) mtail = mhead;
    chk("count", 32'(count_o), 32'(v.cnt));
    chk("empty", 32'(empty_o), 32'(v.cnt == 5'd0));
    chk("ready", 32'(dispatch_ready_o), 32'(v.rdy));
    chk("retire_valid", 32'(retire_valid_o), 32'(v.rv));
    chk("flush", 32'(flush_o), 32'(v.fl));
    chk("flush_pc", flush_pc_o, v.fl ? mpc[mhead] : 32'h0);
    for (int j = 0; j < 2; j++) begin
      if (retire_valid_o[j]) begin
        if (q.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL sb_empty: lane %0d retired, none expected", j);
        end else begin
          e = q.pop_front();
          chk("ret_dest", 32'(retire_dest_o[j*6 +: 6]), 32'(e.d));
          chk("ret_old", 32'(retire_old_dest_o[j*6 +: 6]), 32'(e.o));
          chk("ret_rw", 32'(retire_regwrite_o[j]), 32'(e.rw));
          chk("ret_val", retire_val_o[j*32 +: 32], e.v);
        end
      end
    end
    if (v.fl) q.delete();
    prev_rv  = v.rv;
    prev_fl  = v.fl;
    prev_cnt = int'(v.cnt);
    dispatch_valid_i = '0;
    complete_valid_i = '0;
    complete_exc_i   = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    nvec = 0; nmis = 0; seq = 0;
    mtail = '0; mhead = '0;
    prev_cnt = 0; prev_rv = '0; prev_fl = 1'b0;
    for (int e = 0; e < 16; e++) begin
      mval[e] = '0;
      mpc[e]  = '0;
    end
    rst_ni = 1'b0;
    dispatch_valid_i = '0; dispatch_dest_i = '0;
    dispatch_old_dest_i = '0; dispatch_regwrite_i = '0;
    dispatch_pc_i = '0; complete_valid_i = '0;
    complete_index_i = '0; complete_val_i = '0;
    complete_exc_i = '0;

    tbl.push_back(mk(2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0));
    tbl.push_back(mk(2'b11, 3'b000, 0, 0, 0, 0, 0, 2, 1, 2'b00, 0));
    tbl.push_back(mk(2'b00, 3'b001, 1, 0, 0, 0, 0, 2, 1, 2'b00, 0));
    tbl.push_back(mk(2'b00, 3'b001, 0, 0, 0, 0, 0, 2, 1, 2'b11, 0));
    tbl.push_back(mk(2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0));
    for (int g = 1; g <= 8; g++)
      tbl.push_back(mk(2'b11, 3'b000, 0, 0, 0, 0, 0,
                       5'(2 * g), g != 8, 2'b00, 0));
    tbl.push_back(mk(2'b11, 3'b000, 0, 0, 0, 0, 0, 16, 0, 2'b00, 0));
    tbl.push_back(mk(2'b00, 3'b011, 2, 3, 0, 0, 0, 16, 0, 2'b11, 0));
    for (int p = 0; p < 5; p++)
      tbl.push_back(mk(2'b00, 3'b011, 4'(4 + 2 * p), 4'(5 + 2 * p),
                       0, 0, 0, 5'(14 - 2 * p), 1, 2'b11, 0));
    tbl.push_back(mk(2'b00, 3'b001, 14, 0, 0, 0, 0, 4, 1, 2'b01, 0));
    tbl.push_back(mk(2'b00, 3'b000, 0, 0, 0, 0, 0, 3, 1, 2'b00, 0));
    tbl.push_back(mk(2'b00, 3'b011, 15, 0, 0, 0, 0, 3, 1, 2'b11, 0));
    tbl.push_back(mk(2'b00, 3'b000, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0));
    tbl.push_back(mk(2'b00, 3'b001, 1, 0, 0, 1, 0, 1, 0, 2'b00, 1));
    tbl.push_back(mk(2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0));
    tbl.push_back(mk(2'b11, 3'b000, 0, 0, 0, 0, 0, 2, 1, 2'b00, 0));
    tbl.push_back(mk(2'b00, 3'b101, 1, 0, 2, 3'b100, 0, 2, 1, 2'b01, 0));
    tbl.push_back(mk(2'b00, 3'b000, 0, 0, 0, 0, 0, 1, 0, 2'b00, 1));
    tbl.push_back(mk(2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0));
    tbl.push_back(mk(2'b00, 3'b001, 5, 0, 0, 0, 0, 0, 1, 2'b00, 0));
    tbl.push_back(mk(2'b11, 3'b000, 0, 0, 0, 0, 0, 2, 1, 2'b00, 0));
    tbl.push_back(mk(2'b00, 3'b000, 0, 0, 0, 0, 0, 2, 1, 2'b00, 0));
    tbl.push_back(mk(2'b00, 3'b111, 2, 3, 2, 3'b001, 3'b001,
                     2, 1, 2'b11, 0));
    tbl.push_back(mk(2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0));
    for (int g = 1; g <= 5; g++)
      tbl.push_back(mk(2'b11, 3'b000, 0, 0, 0, 0, 0,
                       5'(2 * g), 1, 2'b00, 0));

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_ready", 32'(dispatch_ready_o), 32'd1);
    chk("rst_rv", 32'(retire_valid_o), 32'd0);
    chk("rst_flush", 32'(flush_o), 32'd0);
    rst_ni = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      run(tbl[i]);

    #3;
    rst_ni = 1'b0;
    #1;
    chk("async_count", 32'(count_o), 32'd0);
    chk("async_empty", 32'(empty_o), 32'd1);
    chk("async_ready", 32'(dispatch_ready_o), 32'd1);
    chk("async_rv", 32'(retire_valid_o), 32'd0);
    chk("async_flush", 32'(flush_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mtail = '0; mhead = '0;
    prev_cnt = 0; prev_rv = '0; prev_fl = 1'b0;
    q.delete();
    @(posedge clk_i);
    #1;
    run(mk(2'b11, 3'b000, 0, 0, 0, 0, 0, 2, 1, 2'b00, 0));
    run(mk(2'b00, 3'b011, 0, 1, 0, 0, 0, 2, 1, 2'b11, 0));
    run(mk(2'b00, 3'b000, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
